// File: rtl/andgate_rr_arbiter_if.sv
// Request/response bundle between four requesters and the shared AND-gate arbiter.
// Requester i owns bit i of each 4-bit vector and slice i of the operand buses.
interface andgate_rr_arbiter_if #(
    parameter int WIDTH = 1
);
    logic [3:0]         req_valid;
    logic [3:0]         req_ready;
    logic [4*WIDTH-1:0] req_a;
    logic [4*WIDTH-1:0] req_b;
    logic [3:0]         rsp_valid;
    logic [3:0]         rsp_ready;
    logic [WIDTH-1:0]   rsp_data;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/andgate_rr_arbiter.sv
// Round-robin arbiter sharing one combinational AND-gate among four requesters.
// Operands are registered into the gate, the result is captured and returned.
module andgate_rr_arbiter #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    andgate_rr_arbiter_if.slave   bus,
    output logic [WIDTH-1:0]      gate_a,
    output logic [WIDTH-1:0]      gate_b,
    input  logic [WIDTH-1:0]      gate_c,
    output logic                  busy,
    output logic [CNT_W-1:0]      op_count
);
    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        RESP
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [1:0]       ptr;
    logic [1:0]       gid;
    logic [1:0]       grant;
    logic [1:0]       idx;
    logic             hit;
    logic             accept;
    logic             done;
    logic [3:0]       rsp_valid_q;
    logic [WIDTH-1:0] rsp_data_q;

    // Search starts at ptr and wraps, so the first valid requester wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        hit   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!hit && bus.req_valid[idx]) begin
                grant = idx;
                hit   = 1'b1;
            end
        end
    end

    assign accept = (state == IDLE) && hit;
    assign done   = (state == RESP) && bus.rsp_ready[gid];

    assign bus.req_ready = accept ? (4'b0001 << grant) : 4'b0000;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign busy          = (state != IDLE);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = EVAL;
            EVAL:    state_nx = RESP;
            RESP:    if (done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            gid         <= '0;
            gate_a      <= '0;
            gate_b      <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= '0;
            op_count    <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                gate_a <= bus.req_a[int'(grant)*WIDTH +: WIDTH];
                gate_b <= bus.req_b[int'(grant)*WIDTH +: WIDTH];
                gid    <= grant;
            end
            if (state == EVAL) begin
                rsp_data_q  <= gate_c;
                rsp_valid_q <= 4'b0001 << gid;
            end
            // Pointer moves only on completion, never on grant.
            if (done) begin
                rsp_valid_q <= '0;
                op_count    <= op_count + CNT_W'(1);
                ptr         <= gid + 2'd1;
            end
        end
    end
endmodule
